bus_arbiter_n: RTL and testbench
================================

BUS_ARBITER_N -- requirements
Module: bus_arbiter_n

Interface
REQ-001 Parameter NUM_CORES, default 4: number of requesting cores, legal 2..8.
REQ-002 Parameter DATA_W, default 8: data width.
REQ-003 Parameter ADDR_W, default 9: RAM address width.
REQ-004 Parameter RD_LATENCY, default 1: RAM read latency in cycles, legal 1..4.
REQ-005 clk  in  1  single clock; all state on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset; assertion clears state immediately; deassertion takes effect at the next posedge.
REQ-007 req  in  NUM_CORES  per-core transaction request, level.
REQ-008 we  in  NUM_CORES  per-core type: 1 = write, 0 = read.
REQ-009 addr  in  NUM_CORES*ADDR_W  packed per-core addresses; core i occupies slice [i*ADDR_W +: ADDR_W].
REQ-010 wdata  in  NUM_CORES*DATA_W  packed per-core write data; core i occupies slice [i*DATA_W +: DATA_W].
REQ-011 grant  out  NUM_CORES  one-hot, one-cycle pulse: request accepted.
REQ-012 done  out  NUM_CORES  one-hot, one-cycle pulse: transaction complete; for reads, rdata is valid in the same cycle.
REQ-013 rdata  out  DATA_W  shared read return, registered; holds its value until the next read completes.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 ram_en, ram_we  out  1 each  RAM strobe and write enable.
REQ-016 ram_addr  out  ADDR_W  RAM address; ram_wdata  out  DATA_W  RAM write data.
REQ-017 ram_rdata  in  DATA_W  RAM read data, valid RD_LATENCY edges after the edge that samples ram_en with ram_we=0.

Function
REQ-018 States: IDLE, ACCESS, RD_WAIT; encoding is free.
REQ-019 Arbitration: at each posedge in IDLE, the block picks the first core with req high, scanning from last+1 modulo NUM_CORES; last is the core most recently granted.
REQ-020 On a pick of core i: grant[i]=1, ram_en=1, ram_we=we[i], ram_addr and ram_wdata take core i's slices, last<=i, and next state is ACCESS; all of these outputs are registered.
REQ-021 ACCESS lasts exactly 1 cycle; ram_en and ram_we are deasserted at the edge that leaves ACCESS.
REQ-022 Write: at the edge leaving ACCESS, done[i] goes to 1 and next state is IDLE; a write occupies 2 cycles from grant to done.
REQ-023 Read: ACCESS goes to RD_WAIT with a down-counter loaded to RD_LATENCY-1.
REQ-024 RD_WAIT: the counter decrements each edge; at the edge where the counter is 0, ram_rdata is captured into rdata, done[i] goes to 1, and next state is IDLE.
REQ-025 Read done lands RD_LATENCY+1 edges after the grant edge.
REQ-026 req, we, addr and wdata are ignored outside IDLE; a core holds them stable until it observes grant.
REQ-027 A core whose req is high at an IDLE edge is treated as having a new request, including in a done cycle; back-to-back requests are legal.
REQ-028 Fairness: a core holding req high is granted within NUM_CORES-1 other transactions.
REQ-029 grant and done are never asserted for more than one core, and never for more than one cycle per transaction.
REQ-030 ram_addr and ram_wdata hold their last values when ram_en=0.

Reset
REQ-031 While reset=0: state=IDLE; grant, done, busy, ram_en and ram_we = 0; rdata, ram_addr and ram_wdata = 0; last=NUM_CORES-1, so core 0 has first priority after reset.
REQ-032 Reset asserted mid-transaction abandons that transaction with no done; ram_en and ram_we drop asynchronously.
REQ-033 The first arbitration occurs at the first posedge with reset=1.

Verification
REQ-034 Reset release, then core 2 writes 0xA5 to address 0x17 -> grant[2] and ram_en=ram_we=1 with ram_addr=0x17 and ram_wdata=0xA5 for 1 cycle; done[2] in the next cycle.
REQ-035 RD_LATENCY=3, core 1 reads 0x17 with the RAM model returning 0xA5 -> done[1] and rdata=0xA5 exactly 4 edges after the grant edge; busy high throughout.
REQ-036 All 4 cores request writes at once after reset -> grant order 0,1,2,3, each 2 cycles apart; core 0 re-requesting is granted only after core 3.
REQ-037 Core 0 holds req continuously while core 3 also requests -> grants alternate 0,3,0,3; core 3 never waits more than 1 transaction.
REQ-038 reset asserted in RD_WAIT -> no done, ram_en=0 and busy=0 immediately; after release, a pending core 0 request is granted first.
REQ-039 NUM_CORES=2, DATA_W=16, ADDR_W=12 -> REQ-034 and REQ-036 pass with widened data.

Source files
------------

// File: rtl/bus_arbiter_n_if.sv
// Core-side bus of the shared-RAM arbiter: per-core request vectors in,
// per-core grant/done pulses and the shared read return out.
interface bus_arbiter_n_if #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 9
);
  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        we;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0]        grant;
  logic [NUM_CORES-1:0]        done;
  logic [DATA_W-1:0]           rdata;
  logic                        busy;

  // Cores drive requests and watch the pulses.
  modport master (
    output req, we, addr, wdata,
    input  grant, done, rdata, busy
  );

  // The arbiter consumes requests and produces the pulses.
  modport slave (
    input  req, we, addr, wdata,
    output grant, done, rdata, busy
  );
endinterface

// File: rtl/bus_arbiter_n.sv
// Round-robin arbiter giving NUM_CORES cores single-transaction access to
// one synchronous RAM. One transaction is in flight at a time:
//   IDLE    -> pick a core, drive the RAM strobe for one cycle
//   ACCESS  -> writes finish here, reads wait for the RAM pipeline
//   RD_WAIT -> count down the read latency and capture the return data
// All outputs are registered; reset is asynchronous and active-low.
module bus_arbiter_n #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_n_if.slave    bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic [NUM_CORES-1:0]   done_q, done_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   busy_q, busy_d;
  logic                   ram_en_q, ram_en_d;
  logic                   ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]      ram_wdata_q, ram_wdata_d;

  // Unpacked per-core views of the packed address/data buses.
  logic [ADDR_W-1:0] addr_arr  [NUM_CORES];
  logic [DATA_W-1:0] wdata_arr [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slice
    assign addr_arr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.wdata[g*DATA_W +: DATA_W];
  end

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] scan_idx;
  int               scan_pos;

  // Round-robin pick: first requesting core starting just after last_q.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    scan_idx = '0;
    scan_pos = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      scan_pos = int'(last_q) + k;
      if (scan_pos >= NUM_CORES) begin
        scan_pos = scan_pos - NUM_CORES;
      end
      scan_idx = IDX_W'(scan_pos);
      if (!pick_vld && bus.req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant_d     = '0;
    done_d      = '0;
    rdata_d     = rdata_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d     = NUM_CORES'(1) << pick_idx;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.we[pick_idx];
          ram_addr_d  = addr_arr[pick_idx];
          ram_wdata_d = wdata_arr[pick_idx];
          last_d      = pick_idx;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        // The strobe is a single cycle regardless of transaction type.
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        if (ram_we_q) begin
          done_d  = NUM_CORES'(1) << last_q;
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(RD_LATENCY - 1);
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = ram_rdata;
          done_d  = NUM_CORES'(1) << last_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops the strobe immediately and
  // points last_q at the top core so core 0 wins the first arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_CORES - 1);
      cnt_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n: a 4-core/8-bit/latency-3 instance and a
// 2-core/16-bit/latency-1 instance, each with a small RAM model.
module tb_bus_arbiter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: 4 cores, 8-bit data, latency 3 ----------
  logic        reset_a;
  logic        ram_en_a, ram_we_a;
  logic [8:0]  ram_addr_a;
  logic [7:0]  ram_wdata_a, ram_rdata_a;

  bus_arbiter_n_if #(.NUM_CORES(4), .DATA_W(8), .ADDR_W(9)) ifa ();

  bus_arbiter_n #(.NUM_CORES(4), .DATA_W(8), .ADDR_W(9), .RD_LATENCY(3)) dut_a (
    .clk      (clk),
    .reset    (reset_a),
    .bus      (ifa),
    .ram_en   (ram_en_a),
    .ram_we   (ram_we_a),
    .ram_addr (ram_addr_a),
    .ram_wdata(ram_wdata_a),
    .ram_rdata(ram_rdata_a)
  );

  logic [7:0] mem_a [512];
  logic [7:0] pa [3];
  always @(posedge clk) begin
    if (ram_en_a && ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
    pa[0] <= (ram_en_a && !ram_we_a) ? mem_a[ram_addr_a] : 8'h00;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
  end
  assign ram_rdata_a = pa[2];

  // ---------------- instance B: 2 cores, 16-bit data, latency 1 ---------
  logic        reset_b;
  logic        ram_en_b, ram_we_b;
  logic [11:0] ram_addr_b;
  logic [15:0] ram_wdata_b, ram_rdata_b;

  bus_arbiter_n_if #(.NUM_CORES(2), .DATA_W(16), .ADDR_W(12)) ifb ();

  bus_arbiter_n #(.NUM_CORES(2), .DATA_W(16), .ADDR_W(12), .RD_LATENCY(1)) dut_b (
    .clk      (clk),
    .reset    (reset_b),
    .bus      (ifb),
    .ram_en   (ram_en_b),
    .ram_we   (ram_we_b),
    .ram_addr (ram_addr_b),
    .ram_wdata(ram_wdata_b),
    .ram_rdata(ram_rdata_b)
  );

  logic [15:0] mem_b [4096];
  logic [15:0] pb;
  always @(posedge clk) begin
    if (ram_en_b && ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
    pb <= (ram_en_b && !ram_we_b) ? mem_b[ram_addr_b] : 16'h0000;
  end
  assign ram_rdata_b = pb;

  // ---------------- helpers --------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int core, input logic w, input logic [8:0] a, input logic [7:0] d);
    ifa.we[core]             = w;
    ifa.addr[core*9 +: 9]    = a;
    ifa.wdata[core*8 +: 8]   = d;
    ifa.req[core]            = 1'b1;
  endtask

  task automatic set_b(input int core, input logic w, input logic [11:0] a, input logic [15:0] d);
    ifb.we[core]             = w;
    ifb.addr[core*12 +: 12]  = a;
    ifb.wdata[core*16 +: 16] = d;
    ifb.req[core]            = 1'b1;
  endtask

  initial begin
    int ord4 [5];
    int ord2 [4];
    int ord3 [3];
    ord4 = '{0, 1, 2, 3, 0};
    ord2 = '{0, 3, 0, 3};
    ord3 = '{0, 1, 0};

    reset_a = 1'b0; reset_b = 1'b0;
    ifa.req = '0; ifa.we = '0; ifa.addr = '0; ifa.wdata = '0;
    ifb.req = '0; ifb.we = '0; ifb.addr = '0; ifb.wdata = '0;
    step(); step();

    // Reset state
    chk("a_rst_grant", 32'(ifa.grant), 0);
    chk("a_rst_done",  32'(ifa.done), 0);
    chk("a_rst_busy",  32'(ifa.busy), 0);
    chk("a_rst_ram_en", 32'(ram_en_a), 0);
    chk("a_rst_ram_we", 32'(ram_we_a), 0);
    chk("a_rst_ram_addr", 32'(ram_addr_a), 0);
    chk("a_rst_ram_wdata", 32'(ram_wdata_a), 0);
    chk("a_rst_rdata", 32'(ifa.rdata), 0);

    // Core 2 writes 0xA5 to 0x17 right after release
    reset_a = 1'b1;
    set_a(2, 1'b1, 9'h017, 8'hA5);
    step();
    chk("wr_grant", 32'(ifa.grant), 32'h4);
    chk("wr_ram_en", 32'(ram_en_a), 1);
    chk("wr_ram_we", 32'(ram_we_a), 1);
    chk("wr_ram_addr", 32'(ram_addr_a), 32'h17);
    chk("wr_ram_wdata", 32'(ram_wdata_a), 32'hA5);
    chk("wr_busy", 32'(ifa.busy), 1);
    chk("wr_done_early", 32'(ifa.done), 0);
    ifa.req[2] = 1'b0;
    step();
    chk("wr_done", 32'(ifa.done), 32'h4);
    chk("wr_grant_off", 32'(ifa.grant), 0);
    chk("wr_ram_en_off", 32'(ram_en_a), 0);
    chk("wr_busy_off", 32'(ifa.busy), 0);
    chk("wr_addr_hold", 32'(ram_addr_a), 32'h17);

    // Core 1 reads 0x17, latency 3: done 4 edges after grant
    set_a(1, 1'b0, 9'h017, 8'h00);
    step();
    chk("rd_grant", 32'(ifa.grant), 32'h2);
    chk("rd_ram_en", 32'(ram_en_a), 1);
    chk("rd_ram_we", 32'(ram_we_a), 0);
    chk("rd_ram_addr", 32'(ram_addr_a), 32'h17);
    ifa.req[1] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("rd_wait%0d_done", i), 32'(ifa.done), 0);
      chk($sformatf("rd_wait%0d_busy", i), 32'(ifa.busy), 1);
    end
    step();
    chk("rd_done", 32'(ifa.done), 32'h2);
    chk("rd_rdata", 32'(ifa.rdata), 32'hA5);
    chk("rd_busy_off", 32'(ifa.busy), 0);
    step();
    chk("rd_done_pulse", 32'(ifa.done), 0);
    chk("rd_rdata_hold", 32'(ifa.rdata), 32'hA5);

    // All four cores write at once after reset; core 0 re-requests
    reset_a = 1'b0;
    step();
    reset_a = 1'b1;
    for (int i = 0; i < 4; i++) set_a(i, 1'b1, 9'(32'h20 + i), 8'(32'h10 + i));
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("rr%0d_grant", n), 32'(ifa.grant), 32'(1 << ord4[n]));
      chk($sformatf("rr%0d_addr", n), 32'(ram_addr_a), 32'(32'h20 + ord4[n]));
      chk($sformatf("rr%0d_wdata", n), 32'(ram_wdata_a), 32'(32'h10 + ord4[n]));
      if (ord4[n] != 0) ifa.req[ord4[n]] = 1'b0;
      if (n == 4) ifa.req[0] = 1'b0;
      step();
      chk($sformatf("rr%0d_done", n), 32'(ifa.done), 32'(1 << ord4[n]));
      chk($sformatf("rr%0d_grant_off", n), 32'(ifa.grant), 0);
    end
    step();
    chk("rr_quiet_grant", 32'(ifa.grant), 0);
    chk("rr_quiet_busy", 32'(ifa.busy), 0);

    // Cores 0 and 3 both hold req: grants alternate 0,3,0,3
    reset_a = 1'b0;
    step();
    reset_a = 1'b1;
    set_a(0, 1'b1, 9'h030, 8'h55);
    set_a(3, 1'b1, 9'h033, 8'h66);
    for (int n = 0; n < 4; n++) begin
      step();
      chk($sformatf("alt%0d_grant", n), 32'(ifa.grant), 32'(1 << ord2[n]));
      if (n == 3) ifa.req = '0;
      step();
      chk($sformatf("alt%0d_done", n), 32'(ifa.done), 32'(1 << ord2[n]));
    end
    step();
    chk("alt_quiet_grant", 32'(ifa.grant), 0);

    // Reset during ACCESS drops the strobe without a clock edge
    set_a(1, 1'b1, 9'h040, 8'h77);
    step();
    chk("acc_grant", 32'(ifa.grant), 32'h2);
    chk("acc_ram_en", 32'(ram_en_a), 1);
    ifa.req[1] = 1'b0;
    #2 reset_a = 1'b0;
    #1;
    chk("acc_rst_ram_en", 32'(ram_en_a), 0);
    chk("acc_rst_ram_we", 32'(ram_we_a), 0);
    chk("acc_rst_busy", 32'(ifa.busy), 0);
    chk("acc_rst_grant", 32'(ifa.grant), 0);
    step();
    chk("acc_rst_no_done", 32'(ifa.done), 0);
    chk("acc_rst_addr", 32'(ram_addr_a), 0);
    reset_a = 1'b1;

    // Reset during RD_WAIT abandons the read; core 0 then wins over core 3
    set_a(2, 1'b0, 9'h017, 8'h00);
    step();
    chk("rw_grant", 32'(ifa.grant), 32'h4);
    ifa.req[2] = 1'b0;
    step();
    chk("rw_busy1", 32'(ifa.busy), 1);
    set_a(0, 1'b1, 9'h050, 8'h88);
    set_a(3, 1'b1, 9'h053, 8'h99);
    step();
    chk("rw_busy2", 32'(ifa.busy), 1);
    chk("rw_ignore_req", 32'(ifa.grant), 0);
    #2 reset_a = 1'b0;
    #1;
    chk("rw_rst_busy", 32'(ifa.busy), 0);
    chk("rw_rst_ram_en", 32'(ram_en_a), 0);
    chk("rw_rst_done", 32'(ifa.done), 0);
    step();
    chk("rw_rst_done2", 32'(ifa.done), 0);
    step();
    chk("rw_rst_done3", 32'(ifa.done), 0);
    chk("rw_rst_rdata", 32'(ifa.rdata), 0);
    reset_a = 1'b1;
    step();
    chk("rw_post_grant0", 32'(ifa.grant), 32'h1);
    chk("rw_post_addr0", 32'(ram_addr_a), 32'h50);
    ifa.req[0] = 1'b0;
    step();
    chk("rw_post_done0", 32'(ifa.done), 32'h1);
    step();
    chk("rw_post_grant3", 32'(ifa.grant), 32'h8);
    chk("rw_post_addr3", 32'(ram_addr_a), 32'h53);
    ifa.req[3] = 1'b0;
    step();
    chk("rw_post_done3", 32'(ifa.done), 32'h8);

    // Instance B: reset state, widened write, latency-1 read, round-robin
    chk("b_rst_grant", 32'(ifb.grant), 0);
    chk("b_rst_rdata", 32'(ifb.rdata), 0);
    chk("b_rst_ram_en", 32'(ram_en_b), 0);
    reset_b = 1'b1;
    set_b(1, 1'b1, 12'h5A3, 16'hBEEF);
    step();
    chk("b_wr_grant", 32'(ifb.grant), 32'h2);
    chk("b_wr_ram_en", 32'(ram_en_b), 1);
    chk("b_wr_ram_we", 32'(ram_we_b), 1);
    chk("b_wr_addr", 32'(ram_addr_b), 32'h5A3);
    chk("b_wr_wdata", 32'(ram_wdata_b), 32'hBEEF);
    ifb.req[1] = 1'b0;
    step();
    chk("b_wr_done", 32'(ifb.done), 32'h2);
    chk("b_wr_ram_en_off", 32'(ram_en_b), 0);

    set_b(0, 1'b0, 12'h5A3, 16'h0000);
    step();
    chk("b_rd_grant", 32'(ifb.grant), 32'h1);
    chk("b_rd_ram_we", 32'(ram_we_b), 0);
    ifb.req[0] = 1'b0;
    step();
    chk("b_rd_wait_done", 32'(ifb.done), 0);
    chk("b_rd_wait_busy", 32'(ifb.busy), 1);
    step();
    chk("b_rd_done", 32'(ifb.done), 32'h1);
    chk("b_rd_rdata", 32'(ifb.rdata), 32'hBEEF);

    reset_b = 1'b0;
    step();
    reset_b = 1'b1;
    set_b(0, 1'b1, 12'h100, 16'h1111);
    set_b(1, 1'b1, 12'h101, 16'h2222);
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("b_rr%0d_grant", n), 32'(ifb.grant), 32'(1 << ord3[n]));
      chk($sformatf("b_rr%0d_wdata", n), 32'(ram_wdata_b), (ord3[n] == 0) ? 32'h1111 : 32'h2222);
      if (ord3[n] == 1) ifb.req[1] = 1'b0;
      if (n == 2) ifb.req[0] = 1'b0;
      step();
      chk($sformatf("b_rr%0d_done", n), 32'(ifb.done), 32'(1 << ord3[n]));
    end
    step();
    chk("b_rr_quiet", 32'(ifb.grant), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
